// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants used by the TX FSM and the TX holding FIFO.
//   UART_DATA_W   default frame width (bits per byte sent)
//   TX_FIFO_DEPTH default TX holding buffer depth
//   cnt_w()       width of a level counter able to hold 0..depth
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int TX_FIFO_DEPTH = 8;
  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: system-side write port, status, and TX-FSM launch handshake of the TX FIFO.
//   master: drives wr_en, wr_data, clr_ovf, busy; observes full, empty, level, overflow, P_DATA, Data_Valid
//   slave : the FIFO itself, the mirror image
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int DEPTH      = TX_FIFO_DEPTH
);
  localparam int CNT_W = cnt_w(DEPTH);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      level;
  logic                  overflow;
  logic                  clr_ovf;
  logic                  busy;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  modport master (
    output wr_en, wr_data, clr_ovf, busy,
    input  full, empty, level, overflow, P_DATA, Data_Valid
  );
  modport slave (
    input  wr_en, wr_data, clr_ovf, busy,
    output full, empty, level, overflow, P_DATA, Data_Valid
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_WIDTH storage, synchronous write, combinational read.
//   clk            write clock
//   we/waddr/wdata write port
//   raddr/rdata    asynchronous read port
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: TX holding buffer that launches one byte at a time into the UART TX FSM.
//   clk   rising-edge clock
//   reset asynchronous active-low reset
//   bus   slave side of uart_tx_fifo_if (write port, status, P_DATA/Data_Valid launch, busy)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int DEPTH      = TX_FIFO_DEPTH
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d, rdata;
  logic                  dv_q, dv_d, ovf_q, ovf_d;
  logic                  full, empty, push, pop;
  uart_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
  // full/empty come from the registered level only, so a pop never frees
  // room for a write at the same edge and a fresh write is never popped at once.
  // Gating the launch on dv_q guarantees at least one idle cycle between pulses,
  // giving the FSM time to raise busy.
  always_comb begin
    full     = level_q == CNT_W'(DEPTH);
    empty    = level_q == '0;
    push     = bus.wr_en && !full;
    pop      = !empty && !bus.busy && !dv_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + CNT_W'(push) - CNT_W'(pop);
    p_data_d = pop ? rdata : p_data_q;
    dv_d     = pop;
    ovf_d    = (bus.wr_en && full) || (ovf_q && !bus.clr_ovf);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      p_data_q <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      p_data_q <= p_data_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
    end
  end
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = level_q;
  assign bus.overflow   = ovf_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = dv_q;
endmodule
